// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: FSM states, access op and
// word-index sizing.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 single-port synchronous RAM with write enable and registered read.
// Only the read register is reset; the storage itself is left uninitialised.
module dmem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave for the MEM stage: latches a request, waits
// WAIT_CYCLES, performs the access, then strobes ready for one cycle.
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall
);

    localparam int unsigned AW = idx_width(DEPTH);
    // The IDLE cycle that accepts the request already counts as the first
    // wait state, so BUSY runs for WAIT_CYCLES cycles in total.
    localparam int unsigned CntLoadI = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
    localparam logic [3:0]  CntLoad  = CntLoadI[3:0];

    state_e        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    op_e           r_op;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_ready;

    logic          w_req;
    op_e           w_op_in;
    logic [AW-1:0] w_idx_in;
    logic          w_access;
    logic          w_direct;
    op_e           w_acc_op;
    logic [AW-1:0] w_acc_idx;
    logic [31:0]   w_acc_wdata;
    logic          w_we;
    logic          w_re;

    assign w_req    = memRead | memWrite;
    assign w_op_in  = memWrite ? OP_WR : OP_RD;
    assign w_idx_in = addr[AW+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        w_direct    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access    = 1'b1;
                        w_direct    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt   = CntLoad;
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_acc_op    = w_direct ? w_op_in  : r_op;
    assign w_acc_idx   = w_direct ? w_idx_in : r_idx;
    assign w_acc_wdata = w_direct ? wdata    : r_wdata;
    assign w_we        = w_access & (w_acc_op == OP_WR) & ~rst;
    assign w_re        = w_access & (w_acc_op == OP_RD) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_op    <= OP_RD;
            r_idx   <= '0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_access;
            if (r_state == IDLE && w_req) begin
                r_op    <= w_op_in;
                r_idx   <= w_idx_in;
                r_wdata <= wdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (rdata)
    );

    assign ready = r_ready;
    assign stall = w_req & (r_state != DONE) & ~rst;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none; load results are checked through an expected-data queue.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] a2, d2, a0, d0;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, stall2, stall0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .memRead(rd2), .memWrite(wr2), .addr(a2), .wdata(d2),
        .rdata(rdata2), .ready(ready2), .stall(stall2)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .memRead(rd0), .memWrite(wr0), .addr(a0), .wdata(d0),
        .rdata(rdata0), .ready(ready0), .stall(stall0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            rd0 = rd; wr0 = wr; a0 = a; d0 = d;
        end else begin
            rd2 = rd; wr2 = wr; a2 = a; d2 = d;
        end
    endtask

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? rdata0 : rdata2;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? ready0 : ready2;
    endfunction

    function automatic logic get_stall(input bit sel);
        return sel ? stall0 : stall2;
    endfunction

    // One access starting at the next falling edge; a_late replaces addr from the
    // second cycle on. Inputs stay asserted through the ready cycle.
    task automatic access(input string tag, input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] a_late,
                          input logic [31:0] d, input logic [31:0] exp, input int exp_stall);
        int          n_st;
        bit          seen;
        bit          is_ld;
        logic [31:0] rprev;
        logic [31:0] e;
        n_st  = 0;
        seen  = 1'b0;
        is_ld = rd & ~wr;
        @(negedge clk);
        rprev = get_rdata(sel);
        drive(sel, rd, wr, a, d);
        if (is_ld) exp_q.push_back(exp);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (get_ready(sel) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (get_stall(sel) === 1'b1) n_st++;
            @(negedge clk);
            if (c == 0) drive(sel, rd, wr, a_late, d);
        end
        chk({tag, " ready seen"}, 32'(seen), 32'd1);
        chk({tag, " stall cycles"}, 32'(n_st), 32'(exp_stall));
        if (is_ld) begin
            e = exp_q.pop_front();
            if (seen) chk({tag, " rdata"}, get_rdata(sel), e);
        end else if (seen) begin
            chk({tag, " rdata kept"}, get_rdata(sel), rprev);
        end
        if (seen) chk({tag, " stall@ready"}, 32'(get_stall(sel)), 32'd0);
    endtask

    task automatic go_idle(input bit sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);

        // Reset held two cycles with loads requested
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst stall2", 32'(stall2), 32'd0);
            chk("rst ready2", 32'(ready2), 32'd0);
            chk("rst rdata2", rdata2, 32'h0);
            chk("rst stall0", 32'(stall0), 32'd0);
            chk("rst rdata0", rdata0, 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("post-rst stall2", 32'(stall2), 32'd1);
        chk("post-rst stall0", 32'(stall0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort ready2", 32'(ready2), 32'd0);

        // Store then load, two wait states
        access("st 10", 1'b0, 1'b0, 1'b1, 32'h10, 32'h10, 32'hDEADBEEF, 32'h0, 3);
        access("ld 10", 1'b0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        go_idle(1'b0);

        // Zero wait states, back-to-back
        access("w0 st 0", 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1, 32'h0, 1);
        access("w0 st 4", 1'b1, 1'b0, 1'b1, 32'h4, 32'h4, 32'h2, 32'h0, 1);
        access("w0 ld 0", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1, 1);
        access("w0 ld 4", 1'b1, 1'b1, 1'b0, 32'h4, 32'h4, 32'h0, 32'h2, 1);
        access("w0 st 8", 1'b1, 1'b0, 1'b1, 32'h8, 32'h8, 32'h77, 32'h0, 1);
        go_idle(1'b1);

        // Wrap/alignment with both request lines high
        access("wrap st", 1'b0, 1'b1, 1'b1, 32'h403, 32'h403, 32'hA5, 32'h0, 3);
        access("wrap ld", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'hA5, 3);

        // Reset during BUSY aborts an uncommitted store
        access("pre st 20", 1'b0, 1'b0, 1'b1, 32'h20, 32'h20, 32'h1111, 32'h0, 3);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h2222);
        #1;
        chk("abort st stall", 32'(stall2), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stall under rst", 32'(stall2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("abort st ready", 32'(ready2), 32'd0);
        access("ld 20", 1'b0, 1'b1, 1'b0, 32'h20, 32'h20, 32'h0, 32'h1111, 3);

        // Address change while BUSY is ignored
        access("st 8", 1'b0, 1'b0, 1'b1, 32'h8, 32'h8, 32'h8888, 32'h0, 3);
        access("st C", 1'b0, 1'b0, 1'b1, 32'hC, 32'hC, 32'hCCCC, 32'h0, 3);
        access("ld 8 chg", 1'b0, 1'b1, 1'b0, 32'h8, 32'hC, 32'h0, 32'h8888, 3);
        go_idle(1'b0);
        @(negedge clk);
        #1;
        chk("idle stall2", 32'(stall2), 32'd0);
        chk("idle ready2", 32'(ready2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
